pipelined_ctrl_unit: RTL and testbench
======================================

// Module: pipelined_ctrl_unit
// PURPOSE
//  Decode stage control for the 5-stage MIPS pipeline. Decodes the 6-bit opcode in ID and
//  carries the control word down through the ID/EX, EX/MEM and MEM/WB registers. Detects
//  load-use hazards (stall), applies branch flushes and resolves destination register index.
//  Flags illegal opcodes and keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  REGW    5   register index width (rs/rt/rd/dst)
//  ALUOPW  3   ALU-op width, >=3; 000 add, 001 sub, 010 R-funct, 011 or, 100 and, 101 slt
//  CNTW    16  stall-cycle counter width
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  id_valid     in   1       IF/ID holds a valid instruction
//  op_code      in   6       instruction[31:26]
//  rs,rt,rd     in   REGW    instruction register fields
//  flush        in   1       branch taken in EX: kill instruction now in ID
//  stall        out  1       comb; hold PC and IF/ID, bubble ID/EX
//  id_jump      out  1       comb; j/jal decoded in ID (PC redirect)
//  id_branch    out  2       comb; {bne,beq} decoded in ID
//  ex_regdst    out  2       ID/EX: 00 rt, 01 rd, 10 $31
//  ex_aluop     out  ALUOPW  ID/EX ALU op
//  ex_alusrc    out  1       ID/EX: 1 = immediate operand
//  ex_dst       out  REGW    ID/EX resolved destination (0 if no regwrite)
//  mem_memread  out  1       EX/MEM
//  mem_memwrite out  1       EX/MEM
//  mem_dst      out  REGW    EX/MEM destination
//  wb_regwrite  out  1       MEM/WB
//  wb_memtoreg  out  2       MEM/WB: 00 ALU, 01 memory, 10 PC+4
//  wb_dst       out  REGW    MEM/WB destination
//  illegal      out  1       registered 1-cycle pulse: unknown opcode in ID last cycle
//  stall_cnt    out  CNTW    saturating count of stall cycles
// BEHAVIOUR
//  Decode (comb, gated by id_valid): R 000000 {rd,aluop 010,regwr}; lw 100011 {rt,add,
//   alusrc,memread,memtoreg 01,regwr}; sw 101011 {add,alusrc,memwrite}; beq 000100 /
//   bne 000101 {sub,branch}; j 000010 {jump}; jal 000011 {$31,memtoreg 10,jump,regwr};
//   addi 001000 {rt,add,alusrc,regwr}; andi 001100 and; ori 001101 or; slti 001010 slt.
//  Any other opcode: all-zero control word (bubble), illegal=1 next cycle.
//  Dst: regdst mux -> rt/rd/31; forced to 0 when regwrite=0; writes to $0 never hazard.
//  uses_rt = R, sw, beq, bne. stall = id_valid & ID/EX.memread & ex_dst!=0 &
//   (ex_dst==rs | (uses_rt & ex_dst==rt)) & !flush.
//  Each edge: ID/EX <- bubble if (stall|flush|!id_valid) else decoded word; EX/MEM <- ID/EX;
//   MEM/WB <- EX/MEM. No back-pressure below ID; later stages always advance.
//  Latency: decoded word visible on ex_* 1 cycle, mem_* 2, wb_* 3 cycles after ID.
//  flush has priority over stall; a flushed instruction never raises illegal.
//  id_jump/id_branch are zero when flush=1 or id_valid=0.
//  stall_cnt increments on each cycle stall=1, holds at 2^CNTW-1.
//  Reset (async, any time incl. mid-stall): all pipe registers = bubble (all zeros),
//   illegal=0, stall_cnt=0; in-flight instructions discarded; comb outputs follow inputs.
// TESTING
//  lw $5 then add $6,$5,$7 -> stall=1 exactly one cycle, add reaches ex_* one cycle late,
//   stall_cnt=1.
//  lw $5 then sw $5,0($2) -> stall (rt use); lw $0 then add using $0 -> no stall.
//  add $3,$1,$2 stream -> ex_dst=3 @+1, mem_dst=3 @+2, wb_regwrite=1,wb_dst=3 @+3.
//  jal -> id_jump=1, ex_regdst=10, wb_dst=31, wb_memtoreg=10; flush with beq in ID ->
//   id_branch=0, ex_* bubble, no stall even if hazard present.
//  op_code 111111 valid -> all ex_* zero, illegal=1 for one cycle; same with flush -> 0.
//  CNTW=2, 5 consecutive hazards -> stall_cnt=3; assert rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/pipelined_ctrl_unit_if.sv
// Control-unit bus: ID-stage instruction fields in, per-stage control words out.
interface pipelined_ctrl_unit_if #(
  parameter int REGW   = 5,
  parameter int ALUOPW = 3,
  parameter int CNTW   = 16
);
  logic              id_valid;
  logic [5:0]        op_code;
  logic [REGW-1:0]   rs;
  logic [REGW-1:0]   rt;
  logic [REGW-1:0]   rd;
  logic              flush;
  logic              stall;
  logic              id_jump;
  logic [1:0]        id_branch;
  logic [1:0]        ex_regdst;
  logic [ALUOPW-1:0] ex_aluop;
  logic              ex_alusrc;
  logic [REGW-1:0]   ex_dst;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [REGW-1:0]   mem_dst;
  logic              wb_regwrite;
  logic [1:0]        wb_memtoreg;
  logic [REGW-1:0]   wb_dst;
  logic              illegal;
  logic [CNTW-1:0]   stall_cnt;

  modport slave (
    input  id_valid, op_code, rs, rt, rd, flush,
    output stall, id_jump, id_branch, ex_regdst, ex_aluop, ex_alusrc, ex_dst,
           mem_memread, mem_memwrite, mem_dst, wb_regwrite, wb_memtoreg, wb_dst,
           illegal, stall_cnt
  );

  modport master (
    output id_valid, op_code, rs, rt, rd, flush,
    input  stall, id_jump, id_branch, ex_regdst, ex_aluop, ex_alusrc, ex_dst,
           mem_memread, mem_memwrite, mem_dst, wb_regwrite, wb_memtoreg, wb_dst,
           illegal, stall_cnt
  );
endinterface

// File: rtl/pipelined_ctrl_unit.sv
// MIPS 5-stage decode control: opcode decode, load-use stall, flush bubbles,
// control word pipelining through ID/EX, EX/MEM, MEM/WB, illegal flag, stall counter.
module pipelined_ctrl_unit #(
  parameter int REGW   = 5,
  parameter int ALUOPW = 3,
  parameter int CNTW   = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_ctrl_unit_if.slave bus
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic [1:0]        d_regdst;
  logic [ALUOPW-1:0] d_aluop;
  logic              d_alusrc, d_memread, d_memwrite, d_regwrite;
  logic [1:0]        d_memtoreg;
  logic              d_jump;
  logic [1:0]        d_branch;
  logic              d_known, d_uses_rt;
  logic [REGW-1:0]   d_dst;

  always_comb begin
    d_regdst   = '0;
    d_aluop    = '0;
    d_alusrc   = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_regwrite = 1'b0;
    d_memtoreg = '0;
    d_jump     = 1'b0;
    d_branch   = '0;
    d_known    = 1'b1;
    d_uses_rt  = 1'b0;
    case (bus.op_code)
      OP_R:    begin d_regdst = 2'b01; d_aluop = ALUOPW'(3'b010); d_regwrite = 1'b1; d_uses_rt = 1'b1; end
      OP_LW:   begin d_alusrc = 1'b1; d_memread = 1'b1; d_memtoreg = 2'b01; d_regwrite = 1'b1; end
      OP_SW:   begin d_alusrc = 1'b1; d_memwrite = 1'b1; d_uses_rt = 1'b1; end
      OP_BEQ:  begin d_aluop = ALUOPW'(3'b001); d_branch = 2'b01; d_uses_rt = 1'b1; end
      OP_BNE:  begin d_aluop = ALUOPW'(3'b001); d_branch = 2'b10; d_uses_rt = 1'b1; end
      OP_J:    d_jump = 1'b1;
      OP_JAL:  begin d_regdst = 2'b10; d_memtoreg = 2'b10; d_jump = 1'b1; d_regwrite = 1'b1; end
      OP_ADDI: begin d_alusrc = 1'b1; d_regwrite = 1'b1; end
      OP_ANDI: begin d_aluop = ALUOPW'(3'b100); d_alusrc = 1'b1; d_regwrite = 1'b1; end
      OP_ORI:  begin d_aluop = ALUOPW'(3'b011); d_alusrc = 1'b1; d_regwrite = 1'b1; end
      OP_SLTI: begin d_aluop = ALUOPW'(3'b101); d_alusrc = 1'b1; d_regwrite = 1'b1; end
      default: d_known = 1'b0;
    endcase
  end

  // Non-writing instructions carry dst=0 so they can never match a hazard compare.
  always_comb begin
    d_dst = bus.rt;
    if (d_regdst == 2'b01) d_dst = bus.rd;
    else if (d_regdst == 2'b10) d_dst = REGW'(31);
    if (!d_regwrite) d_dst = '0;
  end

  logic [1:0]        ex_regdst_q;
  logic [ALUOPW-1:0] ex_aluop_q;
  logic              ex_alusrc_q, ex_memread_q, ex_memwrite_q, ex_regwrite_q;
  logic [1:0]        ex_memtoreg_q;
  logic [REGW-1:0]   ex_dst_q;
  logic              mem_memread_q, mem_memwrite_q, mem_regwrite_q;
  logic [1:0]        mem_memtoreg_q;
  logic [REGW-1:0]   mem_dst_q;
  logic              wb_regwrite_q;
  logic [1:0]        wb_memtoreg_q;
  logic [REGW-1:0]   wb_dst_q;
  logic              illegal_q;
  logic [CNTW-1:0]   stall_cnt_q;

  logic hazard, stall, bubble_in, id_live;

  assign id_live   = bus.id_valid & ~bus.flush;
  assign hazard    = ex_memread_q & (ex_dst_q != '0) &
                     ((ex_dst_q == bus.rs) | (d_uses_rt & (ex_dst_q == bus.rt)));
  assign stall     = id_live & hazard;
  assign bubble_in = stall | bus.flush | ~bus.id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_regdst_q    <= '0;
      ex_aluop_q     <= '0;
      ex_alusrc_q    <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memtoreg_q  <= '0;
      ex_dst_q       <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= '0;
      mem_dst_q      <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= '0;
      wb_dst_q       <= '0;
      illegal_q      <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      if (bubble_in) begin
        ex_regdst_q   <= '0;
        ex_aluop_q    <= '0;
        ex_alusrc_q   <= 1'b0;
        ex_memread_q  <= 1'b0;
        ex_memwrite_q <= 1'b0;
        ex_regwrite_q <= 1'b0;
        ex_memtoreg_q <= '0;
        ex_dst_q      <= '0;
      end else begin
        ex_regdst_q   <= d_regdst;
        ex_aluop_q    <= d_aluop;
        ex_alusrc_q   <= d_alusrc;
        ex_memread_q  <= d_memread;
        ex_memwrite_q <= d_memwrite;
        ex_regwrite_q <= d_regwrite;
        ex_memtoreg_q <= d_memtoreg;
        ex_dst_q      <= d_dst;
      end
      mem_memread_q  <= ex_memread_q;
      mem_memwrite_q <= ex_memwrite_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_dst_q      <= ex_dst_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_dst_q       <= mem_dst_q;
      illegal_q      <= id_live & ~d_known;
      if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNTW'(1);
    end
  end

  assign bus.stall        = stall;
  assign bus.id_jump      = id_live & d_jump;
  assign bus.id_branch    = id_live ? d_branch : 2'b00;
  assign bus.ex_regdst    = ex_regdst_q;
  assign bus.ex_aluop     = ex_aluop_q;
  assign bus.ex_alusrc    = ex_alusrc_q;
  assign bus.ex_dst       = ex_dst_q;
  assign bus.mem_memread  = mem_memread_q;
  assign bus.mem_memwrite = mem_memwrite_q;
  assign bus.mem_dst      = mem_dst_q;
  assign bus.wb_regwrite  = wb_regwrite_q;
  assign bus.wb_memtoreg  = wb_memtoreg_q;
  assign bus.wb_dst       = wb_dst_q;
  assign bus.illegal      = illegal_q;
  assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Directed + random bench for pipelined_ctrl_unit against a table-driven pipeline model.
module tb_pipelined_ctrl_unit;
  localparam logic [5:0] R = 6'b000000, J = 6'b000010, JAL = 6'b000011, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, SLTI = 6'b001010,
                         ANDI = 6'b001100, ORI = 6'b001101, LW = 6'b100011, SW = 6'b101011;

  typedef struct packed {
    logic [1:0] regdst;
    logic [2:0] aluop;
    logic       alusrc, memread, memwrite, regwrite;
    logic [1:0] memtoreg;
    logic       jump;
    logic [1:0] branch;
    logic       legal, reads_rt;
  } ctl_t;

  typedef struct packed {
    ctl_t       c;
    logic [4:0] dst;
  } stage_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_ctrl_unit_if bus ();
  pipelined_ctrl_unit_if #(.CNTW(2)) bus2 ();

  assign bus2.id_valid = bus.id_valid;
  assign bus2.op_code  = bus.op_code;
  assign bus2.rs       = bus.rs;
  assign bus2.rt       = bus.rt;
  assign bus2.rd       = bus.rd;
  assign bus2.flush    = bus.flush;

  pipelined_ctrl_unit u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  pipelined_ctrl_unit #(.CNTW(2)) u_dut_w2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int errors = 0;
  int checks = 0;

  stage_t m_ex, m_mem, m_wb;
  logic   m_ill;
  int     m_cnt, m_cnt2;
  logic   obs_stall, obs_jump;
  logic [1:0] obs_branch;

  function automatic ctl_t dec(input logic [5:0] op);
    ctl_t c = '0;
    c.legal = 1'b1;
    case (op)
      R:    begin c.regdst = 2; c.aluop = 2; c.regwrite = 1; c.reads_rt = 1; end
      LW:   begin c.alusrc = 1; c.memread = 1; c.memtoreg = 1; c.regwrite = 1; end
      SW:   begin c.alusrc = 1; c.memwrite = 1; c.reads_rt = 1; c.regdst = 0; end
      BEQ:  begin c.aluop = 1; c.branch = 2'b01; c.reads_rt = 1; end
      BNE:  begin c.aluop = 1; c.branch = 2'b10; c.reads_rt = 1; end
      J:    c.jump = 1;
      JAL:  begin c.regdst = 3; c.memtoreg = 2; c.jump = 1; c.regwrite = 1; end
      ADDI: begin c.alusrc = 1; c.regwrite = 1; end
      ANDI: begin c.aluop = 4; c.alusrc = 1; c.regwrite = 1; end
      ORI:  begin c.aluop = 3; c.alusrc = 1; c.regwrite = 1; end
      SLTI: begin c.aluop = 5; c.alusrc = 1; c.regwrite = 1; end
      default: c = '0;
    endcase
    // regdst here is a symbolic tag: 0=rt, 2=rd, 3=$31; mapped to bus encoding later
    return c;
  endfunction

  function automatic logic [1:0] bus_regdst(input logic [1:0] tag);
    return (tag == 2) ? 2'b01 : (tag == 3) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [4:0] target(input ctl_t c, input logic [4:0] rt, input logic [4:0] rd);
    if (!c.regwrite) return 5'd0;
    if (c.regdst == 3) return 5'd31;
    if (c.regdst == 2) return rd;
    return rt;
  endfunction

  function automatic ctl_t cur_ctl();
    return bus.id_valid ? dec(bus.op_code) : '0;
  endfunction

  function automatic logic exp_stall();
    ctl_t c = cur_ctl();
    logic reads;
    reads = (m_ex.dst == bus.rs) || (c.reads_rt && m_ex.dst == bus.rt);
    return bus.id_valid && !bus.flush && m_ex.c.memread && m_ex.dst != 0 && reads;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic check_all();
    ctl_t c = cur_ctl();
    logic live;
    live = bus.id_valid && !bus.flush;
    obs_stall = bus.stall; obs_jump = bus.id_jump; obs_branch = bus.id_branch;
    chk("stall", bus.stall, exp_stall());
    chk("id_jump", bus.id_jump, live & c.jump);
    chk("id_branch", bus.id_branch, live ? c.branch : 2'b00);
    chk("ex_regdst", bus.ex_regdst, bus_regdst(m_ex.c.regdst));
    chk("ex_aluop", bus.ex_aluop, m_ex.c.aluop);
    chk("ex_alusrc", bus.ex_alusrc, m_ex.c.alusrc);
    chk("ex_dst", bus.ex_dst, m_ex.dst);
    chk("mem_memread", bus.mem_memread, m_mem.c.memread);
    chk("mem_memwrite", bus.mem_memwrite, m_mem.c.memwrite);
    chk("mem_dst", bus.mem_dst, m_mem.dst);
    chk("wb_regwrite", bus.wb_regwrite, m_wb.c.regwrite);
    chk("wb_memtoreg", bus.wb_memtoreg, m_wb.c.memtoreg);
    chk("wb_dst", bus.wb_dst, m_wb.dst);
    chk("illegal", bus.illegal, m_ill);
    chk("stall_cnt", bus.stall_cnt, m_cnt);
    chk("stall_cnt_w2", bus2.stall_cnt, m_cnt2);
  endtask

  task automatic model_step();
    ctl_t c = cur_ctl();
    logic st;
    stage_t nxt;
    st = exp_stall();
    nxt = '0;
    if (!st && !bus.flush && bus.id_valid && c.legal) begin
      nxt.c = c;
      nxt.dst = target(c, bus.rt, bus.rd);
    end
    m_ill = bus.id_valid && !bus.flush && !c.legal;
    m_wb = m_mem; m_mem = m_ex; m_ex = nxt;
    if (st) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic cycle(input logic v, input logic [5:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input logic f);
    bus.id_valid = v; bus.op_code = op; bus.rs = a; bus.rt = b; bus.rd = d; bus.flush = f;
    #3;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  logic [5:0] op_tab [11];

  initial begin
    op_tab = '{R, J, JAL, BEQ, BNE, ADDI, SLTI, ANDI, ORI, LW, SW};
    bus.id_valid = 0; bus.op_code = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0; bus.flush = 0;
    model_reset();
    #2;
    check_all();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    // load-use on rs: one stall cycle, add lands in EX one cycle late
    cycle(1, LW, 5'd2, 5'd5, 5'd0, 0);
    cycle(1, R, 5'd5, 5'd7, 5'd6, 0);
    chk("lw_add_stall", obs_stall, 1);
    chk("lw_add_bubble_ex_dst", bus.ex_dst, 0);
    chk("lw_add_cnt", bus.stall_cnt, 1);
    cycle(1, R, 5'd5, 5'd7, 5'd6, 0);
    chk("lw_add_no_second_stall", obs_stall, 0);
    chk("add_late_ex_dst", bus.ex_dst, 6);

    // load-use through rt of a store; load to $0 never hazards
    cycle(1, LW, 5'd1, 5'd5, 5'd0, 0);
    cycle(1, SW, 5'd2, 5'd5, 5'd0, 0);
    chk("lw_sw_rt_stall", obs_stall, 1);
    cycle(1, SW, 5'd2, 5'd5, 5'd0, 0);
    cycle(1, LW, 5'd1, 5'd0, 5'd0, 0);
    cycle(1, R, 5'd0, 5'd0, 5'd9, 0);
    chk("lw_zero_no_stall", obs_stall, 0);

    // latency of add $3,$1,$2
    cycle(1, R, 5'd1, 5'd2, 5'd3, 0);
    chk("add_ex_dst", bus.ex_dst, 3);
    idle();
    chk("add_mem_dst", bus.mem_dst, 3);
    idle();
    chk("add_wb_regwrite", bus.wb_regwrite, 1);
    chk("add_wb_dst", bus.wb_dst, 3);

    // jal
    cycle(1, JAL, 5'd0, 5'd0, 5'd0, 0);
    chk("jal_id_jump", obs_jump, 1);
    chk("jal_ex_regdst", bus.ex_regdst, 2'b10);
    idle(); idle();
    chk("jal_wb_dst", bus.wb_dst, 31);
    chk("jal_wb_memtoreg", bus.wb_memtoreg, 2'b10);

    // flush beats a pending load-use hazard
    cycle(1, LW, 5'd1, 5'd4, 5'd0, 0);
    cycle(1, BEQ, 5'd4, 5'd4, 5'd0, 1);
    chk("flush_no_stall", obs_stall, 0);
    chk("flush_no_branch", obs_branch, 0);
    chk("flush_ex_aluop", bus.ex_aluop, 0);
    chk("flush_ex_dst", bus.ex_dst, 0);

    // illegal opcode, plain and flushed
    cycle(1, 6'b111111, 5'd0, 5'd0, 5'd0, 0);
    chk("illegal_pulse", bus.illegal, 1);
    chk("illegal_ex_aluop", bus.ex_aluop, 0);
    idle();
    chk("illegal_cleared", bus.illegal, 0);
    cycle(1, 6'b111111, 5'd0, 5'd0, 5'd0, 1);
    chk("illegal_flushed", bus.illegal, 0);

    // saturation of the narrow counter
    for (int i = 0; i < 5; i++) begin
      cycle(1, LW, 5'd1, 5'd5, 5'd0, 0);
      cycle(1, R, 5'd5, 5'd1, 5'd2, 0);
    end
    chk("cnt_w2_saturated", bus2.stall_cnt, 3);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(7) == 0) ? 6'($urandom) : op_tab[$urandom_range(10)];
      cycle($urandom_range(9) != 0, op, 5'($urandom_range(3)), 5'($urandom_range(3)),
            5'($urandom_range(3)), $urandom_range(9) == 0);
    end

    // asynchronous reset in the middle of a stall
    cycle(1, LW, 5'd1, 5'd5, 5'd0, 0);
    bus.id_valid = 1; bus.op_code = R; bus.rs = 5; bus.rt = 1; bus.rd = 2; bus.flush = 0;
    #3;
    chk("pre_reset_stall", bus.stall, 1);
    rst = 1;
    #1;
    model_reset();
    check_all();
    chk("reset_stall_low", bus.stall, 0);
    chk("reset_cnt_zero", bus.stall_cnt, 0);
    @(posedge clk); #1;
    rst = 0;
    idle();
    idle();
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
